// File: rtl/multicycle_add_sub.sv
// multicycle_add_sub: chunk-serial N-bit adder/subtractor, K bits per clock over N/K cycles
// with carry-in, subtract mode, carry-out, signed overflow and valid/ready handshakes.
module multicycle_add_sub #(
   parameter int N = 64,
   parameter int K = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         cikarma,
   input  logic [N-1:0] sayi1,
   input  logic [N-1:0] sayi2,
   input  logic         elde_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] toplam,
   output logic         elde_out,
   output logic         tasma
);
   localparam int M = N / K;
   localparam int CW = M > 1 ? $clog2(M) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;
   logic [N-1:0] a_reg, b_reg;
   logic carry;
   logic [CW-1:0] cnt;
   logic [K-1:0] a_chunk, b_chunk;
   logic [K:0] sum;
   logic last;
   always_comb begin
      a_chunk = a_reg[cnt*K +: K];
      b_chunk = b_reg[cnt*K +: K];
      sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry};
      last = cnt == CW'(M - 1);
   end
   // b_reg holds the post-inversion operand so overflow uses B' directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         toplam <= '0;
         elde_out <= 1'b0;
         tasma <= 1'b0;
         cnt <= '0;
         carry <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_reg <= sayi1;
               b_reg <= cikarma ? ~sayi2 : sayi2;
               carry <= elde_in ^ cikarma;
               cnt <= '0;
               in_ready <= 1'b0;
               state <= CALC;
            end
            CALC: begin
               toplam[cnt*K +: K] <= sum[K-1:0];
               carry <= sum[K];
               cnt <= cnt + 1'b1;
               if (last) begin
                  elde_out <= sum[K];
                  tasma <= (a_reg[N-1] == b_reg[N-1]) && (sum[K-1] != a_reg[N-1]);
                  out_valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
